// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared constants and state type for the 8-way round-robin arbiter
package rr_arbiter8_pkg;

  localparam int NUM_REQ = 8;
  localparam int DATA_W  = 5;
  localparam int ID_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter8_mux8.sv
// rtl/rr_arbiter8_mux8.sv - 8:1 payload multiplexer used to pick the winning requester's data
module mux8 #(
  parameter int W = 5
) (
  input  logic [2:0]   S,
  input  logic [W-1:0] D0,
  input  logic [W-1:0] D1,
  input  logic [W-1:0] D2,
  input  logic [W-1:0] D3,
  input  logic [W-1:0] D4,
  input  logic [W-1:0] D5,
  input  logic [W-1:0] D6,
  input  logic [W-1:0] D7,
  output logic [W-1:0] Y
);

  always_comb begin
    Y = D0;
    case (S)
      3'd1: Y = D1;
      3'd2: Y = D2;
      3'd3: Y = D3;
      3'd4: Y = D4;
      3'd5: Y = D5;
      3'd6: Y = D6;
      3'd7: Y = D7;
      default: Y = D0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-requester round-robin arbiter with a registered one-deep output slot
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter logic [ID_W-1:0] PTR_INIT = 3'd0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] Req,
  input  logic [DATA_W-1:0]  Data0,
  input  logic [DATA_W-1:0]  Data1,
  input  logic [DATA_W-1:0]  Data2,
  input  logic [DATA_W-1:0]  Data3,
  input  logic [DATA_W-1:0]  Data4,
  input  logic [DATA_W-1:0]  Data5,
  input  logic [DATA_W-1:0]  Data6,
  input  logic [DATA_W-1:0]  Data7,
  output logic [NUM_REQ-1:0] Ack,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [DATA_W-1:0]  Out_Data,
  output logic [ID_W-1:0]    Out_Id,
  output logic               Busy
);

  state_t            state, state_n;
  logic [ID_W-1:0]   ptr, ptr_n;
  logic [ID_W-1:0]   sel, sel_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [ID_W-1:0]   winner;
  logic [DATA_W-1:0] mux_y;

  // First set request bit at or after ptr, wrapping 7 -> 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0]    p);
    logic [ID_W-1:0] idx;
    logic            found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = p + ID_W'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner = rr_pick(Req, ptr);

  mux8 #(.W(DATA_W)) u_mux8 (
    .S  (winner),
    .D0 (Data0),
    .D1 (Data1),
    .D2 (Data2),
    .D3 (Data3),
    .D4 (Data4),
    .D5 (Data5),
    .D6 (Data6),
    .D7 (Data7),
    .Y  (mux_y)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    data_n  = data_q;
    case (state)
      IDLE: begin
        if (|Req) begin
          state_n = GRANT;
          sel_n   = winner;
          data_n  = mux_y;
        end
      end
      GRANT: begin
        if (Out_Ready) begin
          state_n = IDLE;
          ptr_n   = sel + ID_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      ptr    <= PTR_INIT;
      sel    <= '0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      sel    <= sel_n;
      data_q <= data_n;
    end
  end

  assign Busy      = (state == GRANT);
  assign Out_Valid = (state == GRANT);
  assign Out_Id    = Out_Valid ? sel : '0;
  assign Out_Data  = Out_Valid ? data_q : '0;
  // Reset wins over a coincident transfer, so the strobe is suppressed here too.
  assign Ack       = (Out_Valid && Out_Ready && !Reset) ? (NUM_REQ'(1) << sel) : '0;

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: PTR_INIT, default 3'd0, round-robin pointer value loaded on Reset.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Req  input  8  per-requester request level; bit i = requester i; held high until Ack[i].
REQ-005 Data0..Data7  input  5 each  payload of requester i.
REQ-006 Ack  output  8  one-hot transfer-accepted strobe, combinational.
REQ-007 Out_Valid  output  1  Out_Data/Out_Id valid toward consumer.
REQ-008 Out_Ready  input  1  consumer can accept.
REQ-009 Out_Data  output  5  registered payload of granted requester.
REQ-010 Out_Id  output  3  index of granted requester.
REQ-011 Busy  output  1  high while in GRANT state.

Function
REQ-012 FSM SHALL have two states, IDLE and GRANT; Busy SHALL equal (state == GRANT).
REQ-013 In IDLE with Req != 0: winner = first set Req bit searching Ptr, Ptr+1, ..., wrapping 7->0; on that edge Sel <= winner, Out_Data <= Data[winner] via mux8, state <= GRANT.
REQ-014 In IDLE with Req == 0: no state change; Out_Valid = 0.
REQ-015 Latency SHALL be one cycle: Req sampled high at edge t -> Out_Valid = 1 in cycle t+1.
REQ-016 In GRANT, Out_Valid = 1, Out_Id = Sel, Out_Data held stable; later changes on Data[Sel] SHALL NOT affect Out_Data.
REQ-017 Transfer occurs in a cycle where Out_Valid && Out_Ready; in that cycle Ack = 8'b1 << Sel; Ack = 0 in every other cycle.
REQ-018 On transfer edge: Ptr <= Sel + 1 (3-bit modulo, 7 -> 0), state <= IDLE.
REQ-019 GRANT with Out_Ready = 0 SHALL hold indefinitely; Ptr, Sel, Out_Data unchanged.
REQ-020 Req[Sel] dropped during GRANT (protocol violation) SHALL NOT abort; transfer completes and Ack[Sel] still pulses.
REQ-021 Out_Ready high while Out_Valid low SHALL have no effect.
REQ-022 Throughput: at most one transfer per two cycles (GRANT -> IDLE -> GRANT).
REQ-023 Just-served requester SHALL have lowest priority at the next arbitration; no requester starves while others request (bounded wait of 8 grants).
REQ-024 Out_Id and Out_Data SHALL read 0 whenever Out_Valid = 0.

Reset
REQ-025 Reset high at an edge: state <= IDLE, Ptr <= PTR_INIT, Sel <= 0, Out_Data register <= 0; outputs Out_Valid = 0, Ack = 0, Busy = 0, Out_Id = 0, Out_Data = 0 from the following cycle.
REQ-026 Reset during GRANT SHALL abandon the grant with no Ack pulse; Reset SHALL take priority over a simultaneous transfer.

Structure
REQ-027 Shared package SHALL hold the state enum (IDLE, GRANT) and constants NUM_REQ = 8, DATA_W = 5, ID_W = 3.
REQ-028 Payload selection SHALL use one instance of existing mux8 with S = winner index during IDLE; the round-robin priority search SHALL be a combinational function in this module.
REQ-029 No further sub-modules; no latches; all registers reset synchronously.

Verification
REQ-030 Reset, Ptr = 0, Req = 8'b0000_0100, Data2 = 5'h15, Out_Ready = 1 -> Out_Valid next cycle, Out_Id = 2, Out_Data = 5'h15, Ack = 8'b0000_0100 in the same cycle; Ptr = 3 afterwards.
REQ-031 Req = 8'hFF held, Out_Ready = 1, each requester drops Req after its Ack -> grant order 0,1,...,7, one Ack every 2 cycles, 8 Acks total.
REQ-032 Ptr = 7 after serving 6, Req = 8'b1000_0001 -> grant 7 first, then 0 (wrap), Ptr = 1 after both.
REQ-033 Grant to 4 with Out_Ready = 0 for 5 cycles, Data4 toggled each cycle -> Out_Valid, Out_Id = 4 and captured Out_Data stable, Ack = 0; Out_Ready = 1 -> single Ack[4].
REQ-034 Reset asserted in GRANT with Out_Ready = 1 in the same cycle -> no Ack, Out_Valid = 0 next cycle, Ptr = PTR_INIT.
REQ-035 Req[3] granted then dropped before Out_Ready -> transfer still completes with Out_Id = 3 and one Ack[3] pulse.
